// File: rtl/pc_trace_pkg.sv
// Shared types for the PC trace monitor: run-control states and halt causes.
// Pure type/constant package, no logic, no latency.
// No backpressure involved; consumers import with pc_trace_pkg::*.
package pc_trace_pkg;

  localparam int HALT_CAUSE_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Encoding is visible on the halt_cause output, so values are fixed.
  typedef enum logic [HALT_CAUSE_W-1:0] {
    NONE  = 2'd0,
    LIMIT = 2'd1,
    BREAK = 2'd2,
    SPIN  = 2'd3
  } halt_cause_t;

endpackage

// File: rtl/pc_trace_monitor_if.sv
// Bundle between the trace monitor and its host: clear, run/sample inputs, read port, status.
// Wires only, no latency of its own.
// No backpressure; the read port is request/response with a fixed one-edge turnaround.
// Ports (slave = monitor side):
//   in : clear, enable, pc_q, pc_d, instruction, reg_write_en, bp_enable, bp_addr, rd_req, rd_idx
//   out: rd_valid, rd_err, rd_pc, rd_instr, rd_rwe, cycle_count, trace_count, running, halt, halt_cause
interface pc_trace_monitor_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
);
  import pc_trace_pkg::*;

  logic                      clear;
  logic                      enable;
  logic [XLEN-1:0]           pc_q;
  logic [XLEN-1:0]           pc_d;
  logic [XLEN-1:0]           instruction;
  logic                      reg_write_en;
  logic                      bp_enable;
  logic [XLEN-1:0]           bp_addr;
  logic                      rd_req;
  logic [$clog2(DEPTH)-1:0]  rd_idx;

  logic                      rd_valid;
  logic                      rd_err;
  logic [XLEN-1:0]           rd_pc;
  logic [XLEN-1:0]           rd_instr;
  logic                      rd_rwe;
  logic [CNT_W-1:0]          cycle_count;
  logic [$clog2(DEPTH):0]    trace_count;
  logic                      running;
  logic                      halt;
  logic [HALT_CAUSE_W-1:0]   halt_cause;

  modport master (
    output clear, enable, pc_q, pc_d, instruction, reg_write_en,
           bp_enable, bp_addr, rd_req, rd_idx,
    input  rd_valid, rd_err, rd_pc, rd_instr, rd_rwe,
           cycle_count, trace_count, running, halt, halt_cause
  );

  modport slave (
    input  clear, enable, pc_q, pc_d, instruction, reg_write_en,
           bp_enable, bp_addr, rd_req, rd_idx,
    output rd_valid, rd_err, rd_pc, rd_instr, rd_rwe,
           cycle_count, trace_count, running, halt, halt_cause
  );

endinterface

// File: rtl/pc_trace_monitor_trace_ram.sv
// Trace storage: DEPTH x WIDTH, one synchronous write port, one registered read port.
// Read data appears after the edge that samples rdEn; a same-edge write is not visible (read-before-write).
// No backpressure. Ports: clock, reset_n, wrEn/wrAddr/wrData, rdEn/rdZero/rdAddr, rdData.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 65
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      wrEn,
  input  logic [$clog2(DEPTH)-1:0]  wrAddr,
  input  logic [WIDTH-1:0]          wrData,
  input  logic                      rdEn,
  input  logic                      rdZero,
  input  logic [$clog2(DEPTH)-1:0]  rdAddr,
  output logic [WIDTH-1:0]          rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  // rdZero lets the owner load zeros (out-of-range read or clear) through the same register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  rdData <= '0;
    else if (rdEn) rdData <= rdZero ? '0 : mem[rdAddr];
  end

endmodule

// File: rtl/pc_trace_monitor.sv
// Run-control and PC trace monitor beside the datapath: captures {pc, instr, rwe} each running cycle,
// halts on breakpoint > self-loop > cycle limit; every output is registered, read data one edge after rd_req.
// No backpressure: capture follows enable, reads are always accepted. Ports: clock, reset_n, bus (slave).
module pc_trace_monitor
  import pc_trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 20
) (
  input  logic                clock,
  input  logic                reset_n,
  pc_trace_monitor_if.slave   bus
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(CYCLE_LIMIT);
  localparam logic [AW:0]      DEPTH_V = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            rwe;
  } trace_entry_t;

  state_t        state, stateNext;
  halt_cause_t   cause, causeNext;
  logic          runQ, haltQ;
  logic [AW-1:0] wrPtr;
  logic [AW:0]   traceCnt;
  logic [CNT_W-1:0] cycleCnt, cycleInc;
  logic          capture, brkHit, spinHit, limHit;
  logic          rdValidQ, rdErrQ, rdInRange;
  logic [AW-1:0] rdBase, rdPhys;
  trace_entry_t  wrEntry, rdEntry;

  assign cycleInc = cycleCnt + CNT_W'(1);
  assign brkHit   = bus.bp_enable && (bus.pc_q == bus.bp_addr);
  assign spinHit  = (bus.pc_d == bus.pc_q);
  // Compared against the count this capture will produce, so the halt lands on the limit-th capture.
  assign limHit   = (CYCLE_LIMIT != 0) && (cycleInc == LIMIT_V);

  always_comb begin
    stateNext = state;
    causeNext = cause;
    capture   = 1'b0;
    if (bus.clear) begin
      stateNext = IDLE;
      causeNext = NONE;
    end else begin
      case (state)
        IDLE: if (bus.enable) stateNext = RUN;
        RUN: if (bus.enable) begin
          capture = 1'b1;
          if (brkHit) begin
            stateNext = HALTED;
            causeNext = BREAK;
          end else if (spinHit) begin
            stateNext = HALTED;
            causeNext = SPIN;
          end else if (limHit) begin
            stateNext = HALTED;
            causeNext = LIMIT;
          end
        end
        HALTED: stateNext = HALTED;
        default: stateNext = IDLE;
      endcase
    end
  end

  // running/halt are decoded from the next state so they are true flops, aligned with state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cause <= NONE;
      runQ  <= 1'b0;
      haltQ <= 1'b0;
    end else begin
      state <= stateNext;
      cause <= causeNext;
      runQ  <= (stateNext == RUN);
      haltQ <= (stateNext == HALTED);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr    <= '0;
      traceCnt <= '0;
      cycleCnt <= '0;
    end else if (bus.clear) begin
      wrPtr    <= '0;
      traceCnt <= '0;
      cycleCnt <= '0;
    end else if (capture) begin
      wrPtr <= wrPtr + AW'(1);   // DEPTH is a power of two, so this wraps naturally
      if (traceCnt != DEPTH_V) traceCnt <= traceCnt + (AW+1)'(1);
      if (cycleCnt != '1)      cycleCnt <= cycleInc;
    end
  end

  // Logical index 0 is the oldest entry: slot 0 until the buffer wraps, then the next write slot.
  assign rdInRange = ({1'b0, bus.rd_idx} < traceCnt);
  assign rdBase    = (traceCnt == DEPTH_V) ? wrPtr : '0;
  assign rdPhys    = rdBase + bus.rd_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdValidQ <= 1'b0;
      rdErrQ   <= 1'b0;
    end else if (bus.clear) begin
      rdValidQ <= 1'b0;
      rdErrQ   <= 1'b0;
    end else begin
      rdValidQ <= bus.rd_req &&  rdInRange;
      rdErrQ   <= bus.rd_req && !rdInRange;
    end
  end

  assign wrEntry = '{pc: bus.pc_q, instr: bus.instruction, rwe: bus.reg_write_en};

  // Read data register is only loaded on a request (or clear), so it holds otherwise.
  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_entry_t))
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .wrEn    (capture),
    .wrAddr  (wrPtr),
    .wrData  (wrEntry),
    .rdEn    (bus.rd_req || bus.clear),
    .rdZero  (bus.clear || !rdInRange),
    .rdAddr  (rdPhys),
    .rdData  (rdEntry)
  );

  assign bus.rd_valid    = rdValidQ;
  assign bus.rd_err      = rdErrQ;
  assign bus.rd_pc       = rdEntry.pc;
  assign bus.rd_instr    = rdEntry.instr;
  assign bus.rd_rwe      = rdEntry.rwe;
  assign bus.cycle_count = cycleCnt;
  assign bus.trace_count = traceCnt;
  assign bus.running     = runQ;
  assign bus.halt        = haltQ;
  assign bus.halt_cause  = cause;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: two instances (cycle limit 20 and limit disabled) share one stimulus,
// checked each cycle against a history-list reference model plus directed scenario checks.
module tb_pc_trace_monitor;

  localparam int NI   = 2;
  localparam int DEP  = 16;
  localparam int HMAX = 4096;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        clear, enable, rwe, bpEn, rdReq;
  logic [31:0] pcQ, pcD, instr, bpAddr;
  logic [3:0]  rdIdx;

  pc_trace_monitor_if #(.XLEN(32), .DEPTH(DEP), .CNT_W(32)) if0 ();
  pc_trace_monitor_if #(.XLEN(32), .DEPTH(DEP), .CNT_W(32)) if1 ();

  assign if0.clear = clear;        assign if1.clear = clear;
  assign if0.enable = enable;      assign if1.enable = enable;
  assign if0.pc_q = pcQ;           assign if1.pc_q = pcQ;
  assign if0.pc_d = pcD;           assign if1.pc_d = pcD;
  assign if0.instruction = instr;  assign if1.instruction = instr;
  assign if0.reg_write_en = rwe;   assign if1.reg_write_en = rwe;
  assign if0.bp_enable = bpEn;     assign if1.bp_enable = bpEn;
  assign if0.bp_addr = bpAddr;     assign if1.bp_addr = bpAddr;
  assign if0.rd_req = rdReq;       assign if1.rd_req = rdReq;
  assign if0.rd_idx = rdIdx;       assign if1.rd_idx = rdIdx;

  pc_trace_monitor #(.XLEN(32), .DEPTH(DEP), .CNT_W(32), .CYCLE_LIMIT(20)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(if0));
  pc_trace_monitor #(.XLEN(32), .DEPTH(DEP), .CNT_W(32), .CYCLE_LIMIT(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(if1));

  logic [31:0] oPc[NI], oIn[NI], oCyc[NI];
  logic        oRw[NI], oV[NI], oE[NI], oRun[NI], oHalt[NI];
  logic [1:0]  oCause[NI];
  logic [4:0]  oTc[NI];
  assign oPc[0] = if0.rd_pc;            assign oPc[1] = if1.rd_pc;
  assign oIn[0] = if0.rd_instr;         assign oIn[1] = if1.rd_instr;
  assign oRw[0] = if0.rd_rwe;           assign oRw[1] = if1.rd_rwe;
  assign oV[0] = if0.rd_valid;          assign oV[1] = if1.rd_valid;
  assign oE[0] = if0.rd_err;            assign oE[1] = if1.rd_err;
  assign oCyc[0] = if0.cycle_count;     assign oCyc[1] = if1.cycle_count;
  assign oTc[0] = if0.trace_count;      assign oTc[1] = if1.trace_count;
  assign oRun[0] = if0.running;         assign oRun[1] = if1.running;
  assign oHalt[0] = if0.halt;           assign oHalt[1] = if1.halt;
  assign oCause[0] = if0.halt_cause;    assign oCause[1] = if1.halt_cause;

  int errors = 0;
  int checks = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: run state 0=idle 1=run 2=halted, full capture history, last read result.
  int          lim[NI] = '{20, 0};
  int          mState[NI], mCause[NI], hLen[NI];
  int unsigned mCyc[NI];
  logic [31:0] hPc[NI][HMAX], hIn[NI][HMAX];
  logic        hRw[NI][HMAX];
  logic        mRv[NI], mRe[NI], mRrw[NI];
  logic [31:0] mRpc[NI], mRin[NI];

  function automatic int held(input int k);
    return (hLen[k] < DEP) ? hLen[k] : DEP;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NI; k++) begin
      mState[k] = 0; mCause[k] = 0; hLen[k] = 0; mCyc[k] = 0;
      mRv[k] = 0; mRe[k] = 0; mRpc[k] = 0; mRin[k] = 0; mRrw[k] = 0;
    end
  endtask

  task automatic modelStep(input int k);
    int cnt, pos;
    cnt = held(k);
    // Read sees the buffer as it was before this edge's capture.
    if (clear) begin
      mRv[k] = 0; mRe[k] = 0; mRpc[k] = 0; mRin[k] = 0; mRrw[k] = 0;
    end else if (rdReq) begin
      if (int'(rdIdx) < cnt) begin
        pos = (hLen[k] - cnt + int'(rdIdx)) % HMAX;
        mRv[k] = 1; mRe[k] = 0;
        mRpc[k] = hPc[k][pos]; mRin[k] = hIn[k][pos]; mRrw[k] = hRw[k][pos];
      end else begin
        mRv[k] = 0; mRe[k] = 1; mRpc[k] = 0; mRin[k] = 0; mRrw[k] = 0;
      end
    end else begin
      mRv[k] = 0; mRe[k] = 0;
    end
    if (clear) begin
      mState[k] = 0; mCause[k] = 0; hLen[k] = 0; mCyc[k] = 0;
    end else if (mState[k] == 0) begin
      if (enable) mState[k] = 1;
    end else if (mState[k] == 1 && enable) begin
      pos = hLen[k] % HMAX;
      hPc[k][pos] = pcQ; hIn[k][pos] = instr; hRw[k][pos] = rwe;
      hLen[k]++;
      if (mCyc[k] != 32'hFFFF_FFFF) mCyc[k]++;
      if (bpEn && pcQ == bpAddr)                        begin mState[k] = 2; mCause[k] = 2; end
      else if (pcD == pcQ)                              begin mState[k] = 2; mCause[k] = 3; end
      else if (lim[k] != 0 && mCyc[k] == lim[k])        begin mState[k] = 2; mCause[k] = 1; end
    end
  endtask

  task automatic compareAll();
    for (int k = 0; k < NI; k++) begin
      checkVal($sformatf("running%0d", k), oRun[k], mState[k] == 1);
      checkVal($sformatf("halt%0d", k), oHalt[k], mState[k] == 2);
      checkVal($sformatf("cause%0d", k), oCause[k], mCause[k]);
      checkVal($sformatf("cycles%0d", k), oCyc[k], mCyc[k]);
      checkVal($sformatf("tcount%0d", k), oTc[k], held(k));
      checkVal($sformatf("rdvalid%0d", k), oV[k], mRv[k]);
      checkVal($sformatf("rderr%0d", k), oE[k], mRe[k]);
      checkVal($sformatf("rdpc%0d", k), oPc[k], mRpc[k]);
      checkVal($sformatf("rdinstr%0d", k), oIn[k], mRin[k]);
      checkVal($sformatf("rdrwe%0d", k), oRw[k], mRrw[k]);
    end
  endtask

  // Inputs change only after a falling edge; the model steps right after the rising edge.
  task automatic tick();
    @(posedge clock);
    for (int k = 0; k < NI; k++) modelStep(k);
    @(negedge clock);
    compareAll();
  endtask

  task automatic quiet();
    clear = 0; enable = 0; rdReq = 0; rdIdx = 0;
  endtask

  task automatic doClear();
    quiet(); clear = 1; tick(); clear = 0;
  endtask

  task automatic startRun();
    quiet(); enable = 1; tick();
  endtask

  task automatic cap(input logic [31:0] pc, input logic [31:0] nxt);
    pcQ = pc; pcD = nxt; instr = $urandom; rwe = 1'($urandom_range(0, 1)); enable = 1; tick();
  endtask

  task automatic readAt(input int idx);
    enable = 0; rdReq = 1; rdIdx = 4'(idx); tick(); rdReq = 0;
  endtask

  logic [31:0] lastIn, curPc;
  logic        lastRw;

  initial begin
    reset_n = 0;
    quiet(); pcQ = 0; pcD = 0; instr = 0; rwe = 0; bpEn = 0; bpAddr = 0;
    modelReset();
    #3 compareAll();
    @(negedge clock); reset_n = 1;

    // Limit halt with buffer wrap
    doClear(); startRun();
    for (int i = 0; i < 20; i++) begin
      cap(32'(i * 4), 32'(i * 4 + 4));
      if (i == 18) checkVal("t1_no_halt_at_19", if0.halt, 0);
    end
    checkVal("t1_halt", if0.halt, 1);
    checkVal("t1_cause", if0.halt_cause, 1);
    checkVal("t1_cycles", if0.cycle_count, 20);
    checkVal("t1_tcount", if0.trace_count, 16);
    readAt(0);  checkVal("t1_oldest_pc", if0.rd_pc, 32'h10);
    readAt(15); checkVal("t1_newest_pc", if0.rd_pc, 32'h4C);
    cap(32'h100, 32'h104);
    checkVal("t1_halt_holds", if0.cycle_count, 20);

    // Breakpoint beats limit; early breakpoint and out-of-range read
    doClear(); bpEn = 1; bpAddr = 32'h4C; startRun();
    for (int i = 0; i < 20; i++) cap(32'(i * 4), 32'(i * 4 + 4));
    checkVal("t2_cause_break", if0.halt_cause, 2);
    doClear(); bpAddr = 32'h8; startRun();
    for (int i = 0; i < 4; i++) cap(32'(i * 4), 32'(i * 4 + 4));
    checkVal("t2_cycles", if0.cycle_count, 3);
    checkVal("t2_tcount", if0.trace_count, 3);
    readAt(3);
    checkVal("t2_rderr", if0.rd_err, 1);
    checkVal("t2_rdvalid", if0.rd_valid, 0);
    bpEn = 0;

    // Spin
    doClear(); startRun();
    for (int i = 0; i < 4; i++) cap(32'h30 + 32'(i * 4), 32'h34 + 32'(i * 4));
    pcQ = 32'h40; pcD = 32'h40; instr = 32'hDEAD_BEEF; rwe = 1; enable = 1; tick();
    lastIn = instr; lastRw = rwe;
    checkVal("t3_cause_spin", if0.halt_cause, 3);
    checkVal("t3_cycles", if0.cycle_count, 5);
    readAt(4);
    checkVal("t3_last_pc", if0.rd_pc, 32'h40);
    checkVal("t3_last_instr", if0.rd_instr, lastIn);
    checkVal("t3_last_rwe", if0.rd_rwe, lastRw);

    // Pause, then clear racing a halt
    doClear(); startRun();
    for (int i = 0; i < 5; i++) cap(32'(i * 4), 32'(i * 4 + 4));
    for (int i = 0; i < 3; i++) begin
      enable = 0; tick();
      checkVal("t4_paused_cycles", if0.cycle_count, 5);
    end
    checkVal("t4_paused_running", if0.running, 1);
    for (int i = 5; i < 7; i++) cap(32'(i * 4), 32'(i * 4 + 4));
    checkVal("t4_resumed_cycles", if0.cycle_count, 7);
    pcQ = 32'h80; pcD = 32'h80; bpEn = 1; bpAddr = 32'h80; enable = 1; clear = 1; tick();
    clear = 0; bpEn = 0;
    checkVal("t4_clear_halt", if0.halt, 0);
    checkVal("t4_clear_running", if0.running, 0);
    checkVal("t4_clear_cycles", if0.cycle_count, 0);
    checkVal("t4_clear_tcount", if0.trace_count, 0);

    // Async reset between edges
    startRun();
    for (int i = 0; i < 6; i++) cap(32'(i * 4), 32'(i * 4 + 4));
    rdReq = 1; rdIdx = 2; enable = 0; tick(); rdReq = 0;
    #2 reset_n = 0;
    #1 modelReset(); compareAll();
    checkVal("t5_reset_cycles", if0.cycle_count, 0);
    @(posedge clock); @(negedge clock); compareAll();
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      enable = 0; tick();
      checkVal("t5_stays_idle", if0.running, 0);
    end
    enable = 1; tick();
    checkVal("t5_runs", if0.running, 1);

    // Read colliding with the 17th capture
    doClear(); startRun();
    for (int i = 0; i < 16; i++) cap(32'(i * 4), 32'(i * 4 + 4));
    pcQ = 32'h40; pcD = 32'h44; enable = 1; rdReq = 1; rdIdx = 0; tick(); rdReq = 0;
    checkVal("t6_rdvalid", if0.rd_valid, 1);
    checkVal("t6_pre_edge_pc", if0.rd_pc, 32'h0);
    readAt(0);
    checkVal("t6_post_wrap_pc", if0.rd_pc, 32'h4);
    for (int i = 17; i < 40; i++) cap(32'(i * 4), 32'(i * 4 + 4));
    checkVal("t6_nolimit_running", if1.running, 1);
    checkVal("t6_nolimit_cycles", if1.cycle_count, 40);

    // Randomized traffic against the model
    doClear(); curPc = 0;
    for (int n = 0; n < 1500; n++) begin
      if (oHalt[0] && oHalt[1]) clear = ($urandom_range(0, 3) == 0);
      else clear = ($urandom_range(0, 79) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) curPc = $urandom & 32'hFFFF_FFFC;
      pcQ = curPc;
      pcD = ($urandom_range(0, 39) == 0) ? curPc : curPc + 4;
      instr = $urandom; rwe = 1'($urandom_range(0, 1));
      bpEn = 1'($urandom_range(0, 1));
      bpAddr = ($urandom_range(0, 24) == 0) ? curPc : curPc + 32'h8;
      rdReq = ($urandom_range(0, 2) == 0); rdIdx = 4'($urandom_range(0, 15));
      tick();
      curPc = pcD;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
